// File: rtl/sha3_squeeze.sv
// sha3_squeeze: streams the Keccak rate portion of a permuted state as 64-bit
// output words, un-swapping each lane's bytes, and requests further
// permutations when a SHAKE output runs past one rate block.
module sha3_squeeze #(
    parameter int unsigned OUTLEN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [2:0]          mode_sel_i,
    input  logic [OUTLEN_W-1:0] outlen_i,
    input  logic [0:1599]       state_i,
    input  logic                state_valid_i,
    output logic                perm_req_o,
    output logic [0:63]         dout_o,
    output logic [3:0]          dout_nbytes_o,
    output logic                dout_valid_o,
    input  logic                dout_ready_i,
    output logic                dout_last_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned LANE_W    = 64;
    localparam int unsigned MAX_LANES = 21;
    localparam int unsigned IDX_W     = 5;
    // Remaining-byte counter must hold both outlen/8 and the 64-byte maximum
    // of the fixed-length modes.
    localparam int unsigned REM_W     = (OUTLEN_W > 10) ? (OUTLEN_W - 3) : 7;
    localparam int unsigned STATE_W   = 1600;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EMIT = 2'd2,
        S_REQ  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_rate_words;
    logic [REM_W-1:0]        r_rem;
    logic [IDX_W-1:0]        r_idx;
    logic [0:63]             r_dout;
    logic [3:0]              r_nbytes;
    logic                    r_valid;
    logic                    r_last;
    logic                    r_perm_req;
    logic                    r_busy;
    logic                    r_done;
    logic [LANE_W-1:0]       r_buf [0:MAX_LANES-1];

    state_t                  w_state;
    logic [IDX_W-1:0]        w_rate_words;
    logic [REM_W-1:0]        w_rem;
    logic [IDX_W-1:0]        w_idx;
    logic [0:63]             w_dout;
    logic [3:0]              w_nbytes;
    logic                    w_valid;
    logic                    w_last;
    logic                    w_perm_req;
    logic                    w_busy;
    logic                    w_done;

    logic                    w_is_shake;
    logic [REM_W-1:0]        w_req_bytes;
    logic [REM_W-1:0]        w_rem_dec;
    logic [IDX_W-1:0]        w_idx_inc;
    logic [LANE_W-1:0]       w_lane;
    logic [3:0]              w_lane_nb;
    logic                    w_capture;
    logic                    w_unused;

    // Lanes past the largest rate and the sub-byte length bits never matter.
    assign w_unused = ^{state_i[LANE_W*MAX_LANES:STATE_W-1], outlen_i[2:0]};

    // Rate in 64-bit words for each mode.
    function automatic logic [IDX_W-1:0] rate_words_f(input logic [2:0] m);
        logic [IDX_W-1:0] r;
        case (m)
            3'd0:    r = IDX_W'(21);
            3'd1:    r = IDX_W'(17);
            3'd2:    r = IDX_W'(9);
            3'd3:    r = IDX_W'(13);
            3'd4:    r = IDX_W'(17);
            3'd5:    r = IDX_W'(18);
            default: r = IDX_W'(17);
        endcase
        return r;
    endfunction

    // Digest size in bytes for the fixed-length modes.
    function automatic logic [REM_W-1:0] fixed_bytes_f(input logic [2:0] m);
        logic [REM_W-1:0] b;
        case (m)
            3'd2:    b = REM_W'(64);
            3'd3:    b = REM_W'(48);
            3'd4:    b = REM_W'(32);
            3'd5:    b = REM_W'(28);
            default: b = REM_W'(32);
        endcase
        return b;
    endfunction

    // Valid bytes in the word about to be presented.
    function automatic logic [3:0] nbytes_f(input logic [REM_W-1:0] rem);
        return (rem >= REM_W'(8)) ? 4'd8 : rem[3:0];
    endfunction

    // Lane byte k (numeric bits [8k+7:8k]) lands in output byte k; bytes past nb are zeroed.
    function automatic logic [0:63] fmt_word(input logic [LANE_W-1:0] lane,
                                             input logic [3:0]        nb);
        logic [0:63] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < nb) begin
                w[8*k +: 8] = lane[8*k +: 8];
            end
        end
        return w;
    endfunction

    assign w_is_shake  = (mode_sel_i == 3'd0) || (mode_sel_i == 3'd1);
    assign w_req_bytes = w_is_shake ? REM_W'(outlen_i[OUTLEN_W-1:3])
                                    : fixed_bytes_f(mode_sel_i);
    assign w_rem_dec   = r_rem - REM_W'(8);
    assign w_idx_inc   = r_idx + IDX_W'(1);
    assign w_capture   = (r_state == S_WAIT) && state_valid_i;

    // Next-state and next-output logic.
    always_comb begin
        w_state      = r_state;
        w_rate_words = r_rate_words;
        w_rem        = r_rem;
        w_idx        = r_idx;
        w_dout       = r_dout;
        w_nbytes     = r_nbytes;
        w_valid      = r_valid;
        w_last       = r_last;
        w_perm_req   = 1'b0;
        w_done       = 1'b0;
        w_lane       = '0;
        w_lane_nb    = 4'd0;

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_req_bytes == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_rate_words = rate_words_f(mode_sel_i);
                        w_rem        = w_req_bytes;
                        w_state      = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (state_valid_i) begin
                    // Word 0 comes straight from the incoming state; the buffer fills in parallel.
                    w_lane    = state_i[0:LANE_W-1];
                    w_lane_nb = nbytes_f(r_rem);
                    w_idx     = '0;
                    w_dout    = fmt_word(w_lane, w_lane_nb);
                    w_nbytes  = w_lane_nb;
                    w_last    = (r_rem <= REM_W'(8));
                    w_valid   = 1'b1;
                    w_state   = S_EMIT;
                end
            end

            S_EMIT: begin
                if (dout_ready_i) begin
                    if (r_last) begin
                        w_state  = S_IDLE;
                        w_valid  = 1'b0;
                        w_last   = 1'b0;
                        w_dout   = '0;
                        w_nbytes = 4'd0;
                        w_rem    = '0;
                        w_idx    = '0;
                        w_done   = 1'b1;
                    end else if (r_idx == (r_rate_words - IDX_W'(1))) begin
                        w_state    = S_REQ;
                        w_valid    = 1'b0;
                        w_last     = 1'b0;
                        w_dout     = '0;
                        w_nbytes   = 4'd0;
                        w_rem      = w_rem_dec;
                        w_perm_req = 1'b1;
                    end else begin
                        w_lane    = r_buf[w_idx_inc];
                        w_lane_nb = nbytes_f(w_rem_dec);
                        w_idx     = w_idx_inc;
                        w_rem     = w_rem_dec;
                        w_dout    = fmt_word(w_lane, w_lane_nb);
                        w_nbytes  = w_lane_nb;
                        w_last    = (w_rem_dec <= REM_W'(8));
                    end
                end
            end

            S_REQ: begin
                w_state = S_WAIT;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rate_words <= '0;
            r_rem        <= '0;
            r_idx        <= '0;
            r_dout       <= '0;
            r_nbytes     <= 4'd0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_perm_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_rate_words <= w_rate_words;
            r_rem        <= w_rem;
            r_idx        <= w_idx;
            r_dout       <= w_dout;
            r_nbytes     <= w_nbytes;
            r_valid      <= w_valid;
            r_last       <= w_last;
            r_perm_req   <= w_perm_req;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    // Rate-lane buffer, loaded once per permuted state.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < MAX_LANES; i++) begin
                r_buf[i] <= state_i[LANE_W*i +: LANE_W];
            end
        end
    end

    assign perm_req_o    = r_perm_req;
    assign dout_o        = r_dout;
    assign dout_nbytes_o = r_nbytes;
    assign dout_valid_o  = r_valid;
    assign dout_last_o   = r_last;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule

// File: tb/tb_sha3_squeeze.sv
// Testbench for sha3_squeeze: random states streamed against a byte-queue model.
module tb_sha3_squeeze;

    localparam int unsigned OUTLEN_W = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start_i;
    logic [2:0]          mode_sel_i;
    logic [OUTLEN_W-1:0] outlen_i;
    logic [0:1599]       state_i;
    logic                state_valid_i;
    logic                perm_req_o;
    logic [0:63]         dout_o;
    logic [3:0]          dout_nbytes_o;
    logic                dout_valid_o;
    logic                dout_ready_i;
    logic                dout_last_o;
    logic                busy_o;
    logic                done_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];

    sha3_squeeze #(.OUTLEN_W(OUTLEN_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .mode_sel_i    (mode_sel_i),
        .outlen_i      (outlen_i),
        .state_i       (state_i),
        .state_valid_i (state_valid_i),
        .perm_req_o    (perm_req_o),
        .dout_o        (dout_o),
        .dout_nbytes_o (dout_nbytes_o),
        .dout_valid_o  (dout_valid_o),
        .dout_ready_i  (dout_ready_i),
        .dout_last_o   (dout_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    function automatic int rate_of(input logic [2:0] m);
        case (m)
            3'd0: return 21;
            3'd1: return 17;
            3'd2: return 9;
            3'd3: return 13;
            3'd4: return 17;
            3'd5: return 18;
            default: return 17;
        endcase
    endfunction

    function automatic int bytes_of(input logic [2:0] m, input int outlen);
        case (m)
            3'd0, 3'd1: return outlen / 8;
            3'd2: return 64;
            3'd3: return 48;
            3'd4: return 32;
            3'd5: return 28;
            default: return 32;
        endcase
    endfunction

    // Drive a fresh random state; append its rate bytes in output order to the model.
    task automatic send_state(input int rate, input bit use_l0, input logic [63:0] l0);
        logic [63:0] lane;
        for (int i = 0; i < 25; i++) begin
            lane = {$urandom, $urandom};
            if (i == 0 && use_l0) lane = l0;
            state_i[64*i +: 64] = lane;
            if (i < rate) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(lane[8*k +: 8]);
            end
        end
        state_valid_i = 1'b1;
    endtask

    // One full request. ready_mode: 0 always ready, 1 random, 2 five-cycle stall at word 3.
    task automatic run_req(input string name, input logic [2:0] mode, input int outlen,
                           input int ready_mode, input bit junk,
                           input bit use_l0, input logic [63:0] l0, input logic [63:0] first_exp);
        int rate, total, nwords_exp, nperm_exp, widx, nperm, ndone, cd, stall_left, iter, nb_exp, bi;
        bit strobe_prev, stall_prev, cont_prev, finished, busy_ok, ready, first_sent, last_exp;
        logic [63:0] held_dout, exp_w;
        logic [3:0]  held_nb;
        logic        held_last;
        rate = rate_of(mode);
        total = bytes_of(mode, outlen);
        nwords_exp = (total + 7) / 8;
        nperm_exp = (total + rate*8 - 1) / (rate*8) - 1;
        exp_q.delete();
        widx = 0; nperm = 0; ndone = 0; stall_left = 5; iter = 0;
        strobe_prev = 0; stall_prev = 0; cont_prev = 0; finished = 0; busy_ok = 1; first_sent = 0;
        held_dout = '0; held_nb = '0; held_last = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1; mode_sel_i = mode; outlen_i = OUTLEN_W'(outlen); dout_ready_i = 1'b0;
        cd = 1;
        while (!finished && iter < 3000) begin
            @(posedge clk); #1;
            iter++;
            start_i = 1'b0;
            state_valid_i = 1'b0;
            if (strobe_prev) begin
                checks++;
                if (dout_valid_o !== 1'b1) begin
                    errors++; $display("FAIL %s valid_latency: got %b want 1", name, dout_valid_o);
                end
            end
            if (cont_prev) begin
                checks++;
                if (dout_valid_o !== 1'b1) begin
                    errors++; $display("FAIL %s back_to_back word %0d: valid %b want 1", name, widx, dout_valid_o);
                end
            end
            if (stall_prev) begin
                checks++;
                if (dout_o !== held_dout || dout_nbytes_o !== held_nb || dout_last_o !== held_last) begin
                    errors++;
                    $display("FAIL %s hold word %0d: got %h/%0d/%b want %h/%0d/%b", name, widx,
                             dout_o, dout_nbytes_o, dout_last_o, held_dout, held_nb, held_last);
                end
            end
            strobe_prev = 0; cont_prev = 0; stall_prev = 0;
            if (done_o === 1'b1) begin
                ndone++; finished = 1;
            end else if (busy_o !== 1'b1) begin
                busy_ok = 0;
            end
            if (perm_req_o === 1'b1) begin
                nperm++;
                cd = 1 + $urandom_range(0, 2);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    send_state(rate, use_l0 && !first_sent, l0);
                    first_sent = 1; strobe_prev = 1;
                end
            end
            if (dout_valid_o === 1'b1 && !finished) begin
                checks++;
                if (widx >= nwords_exp) begin
                    errors++; $display("FAIL %s extra_word %0d: data %h", name, widx, dout_o);
                end else begin
                    nb_exp = (total - 8*widx >= 8) ? 8 : total - 8*widx;
                    last_exp = (total - 8*widx <= 8);
                    exp_w = '0;
                    for (int k = 0; k < nb_exp; k++) begin
                        bi = 8*widx + k;
                        exp_w[63-8*k -: 8] = (bi < exp_q.size()) ? exp_q[bi] : 8'h00;
                    end
                    if (dout_o !== exp_w) begin
                        errors++; $display("FAIL %s data word %0d: got %h want %h", name, widx, dout_o, exp_w);
                    end
                    checks++;
                    if (dout_nbytes_o !== 4'(nb_exp)) begin
                        errors++; $display("FAIL %s nbytes word %0d: got %0d want %0d", name, widx, dout_nbytes_o, nb_exp);
                    end
                    checks++;
                    if (dout_last_o !== last_exp) begin
                        errors++; $display("FAIL %s last word %0d: got %b want %b", name, widx, dout_last_o, last_exp);
                    end
                    if (use_l0 && widx == 0) begin
                        checks++;
                        if (dout_o !== first_exp) begin
                            errors++; $display("FAIL %s first_word: got %h want %h", name, dout_o, first_exp);
                        end
                    end
                end
                case (ready_mode)
                    0: ready = 1;
                    1: ready = ($urandom_range(0, 99) < 60);
                    default: begin
                        if (widx == 3 && stall_left > 0) begin ready = 0; stall_left--; end
                        else ready = 1;
                    end
                endcase
                dout_ready_i = ready;
                if (ready) begin
                    cont_prev = (total - 8*widx > 8) && (((widx + 1) % rate) != 0);
                    widx++;
                end else begin
                    stall_prev = 1;
                    held_dout = dout_o; held_nb = dout_nbytes_o; held_last = dout_last_o;
                end
                if (junk && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        start_i = 1'b1;
                        mode_sel_i = 3'($urandom_range(0, 7));
                        outlen_i = OUTLEN_W'($urandom);
                    end else begin
                        for (int i = 0; i < 50; i++) state_i[32*i +: 32] = $urandom;
                        state_valid_i = 1'b1;
                    end
                end
            end else begin
                dout_ready_i = 1'($urandom_range(0, 1));
            end
        end
        dout_ready_i = 1'b0;
        start_i = 1'b0;
        state_valid_i = 1'b0;
        checks++;
        if (!finished) begin
            errors++; $display("FAIL %s timeout: no done_o after %0d cycles", name, iter);
        end
        checks++;
        if (widx != nwords_exp) begin
            errors++; $display("FAIL %s word_count: got %0d want %0d", name, widx, nwords_exp);
        end
        checks++;
        if (nperm != nperm_exp) begin
            errors++; $display("FAIL %s perm_req_count: got %0d want %0d", name, nperm, nperm_exp);
        end
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL %s done_count: got %0d want 1", name, ndone);
        end
        checks++;
        if (!busy_ok) begin
            errors++; $display("FAIL %s busy: got 0 while request active want 1", name);
        end
        @(posedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || dout_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL %s after_done: done/valid/busy got %b%b%b want 000", name, done_o, dout_valid_o, busy_o);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (perm_req_o !== 1'b0 || dout_o !== 64'h0 || dout_nbytes_o !== 4'd0 || dout_valid_o !== 1'b0 ||
            dout_last_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: req=%b dout=%h nb=%0d valid=%b last=%b busy=%b done=%b want all 0",
                     name, perm_req_o, dout_o, dout_nbytes_o, dout_valid_o, dout_last_o, busy_o, done_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b0; mode_sel_i = '0; outlen_i = '0; state_i = '0;
        state_valid_i = 1'b0; dout_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_shake_zero();
        @(posedge clk); #1;
        start_i = 1'b1; mode_sel_i = 3'd1; outlen_i = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || dout_valid_o !== 1'b0 || perm_req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL shake_zero pulse: done/valid/req/busy got %b%b%b%b want 1000",
                               done_o, dout_valid_o, perm_req_o, busy_o);
        end
        @(posedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || dout_valid_o !== 1'b0) begin
            errors++; $display("FAIL shake_zero after: done/busy/valid got %b%b%b want 000", done_o, busy_o, dout_valid_o);
        end
    endtask

    task automatic test_reset_mid_stream();
        int widx, iter;
        bit hit;
        widx = 0; iter = 0; hit = 0;
        exp_q.delete();
        @(posedge clk); #1;
        start_i = 1'b1; mode_sel_i = 3'd0; outlen_i = OUTLEN_W'(1024);
        @(posedge clk); #1;
        start_i = 1'b0;
        send_state(21, 1'b0, 64'h0);
        dout_ready_i = 1'b1;
        while (!hit && iter < 100) begin
            @(posedge clk); #1;
            iter++;
            state_valid_i = 1'b0;
            if (dout_valid_o === 1'b1) begin
                if (widx == 5) hit = 1;
                else widx++;
            end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL reset_mid reach_word5: got word %0d want 5", widx);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        dout_ready_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_mid_released");
    endtask

    initial begin
        test_reset();
        run_req("sha3_256", 3'd4, 0, 0, 1'b0, 1'b1, 64'h66d71ebff8c6ffa7, 64'ha7ffc6f8bf1ed766);
        run_req("sha3_224", 3'd5, 0, 1, 1'b0, 1'b0, 64'h0, 64'h0);
        run_req("shake128_1352", 3'd0, 1352, 0, 1'b0, 1'b0, 64'h0, 64'h0);
        run_req("backpressure", 3'd2, 0, 2, 1'b0, 1'b0, 64'h0, 64'h0);
        test_shake_zero();
        run_req("ignored_inputs", 3'd3, 0, 1, 1'b1, 1'b0, 64'h0, 64'h0);
        test_reset_mid_stream();
        run_req("sha3_512_after_reset", 3'd2, 0, 0, 1'b0, 1'b0, 64'h0, 64'h0);
        for (int t = 0; t < 6; t++) begin
            run_req($sformatf("random_%0d", t), 3'($urandom_range(0, 7)), 8 * $urandom_range(1, 400),
                    1, 1'b1, 1'b0, 64'h0, 64'h0);
        end
        run_req("shake256_multi", 3'd1, 8 * 300, 1, 1'b1, 1'b0, 64'h0, 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_squeeze.md
Name: sha3_squeeze

Overview:
Output-side counterpart of the absorb padding stage. It takes the 1600-bit Keccak state produced by the permutation and undoes the per-lane byte swap. It then streams the digest or XOF output as 64-bit words over a valid/ready interface. For SHAKE outputs longer than one rate block, it requests further permutations and resumes streaming from each new state.

Parameters:
OUTLEN_W, 16, width of requested output length in bits (SHAKE only); maximum request is 2^OUTLEN_W-8 bits.

Ports:
clk  input  1  clock, all logic rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start_i  input  1  single-cycle request to begin a squeeze; sampled only in IDLE.
mode_sel_i  input  3  0 SHAKE128, 1 SHAKE256, 2 SHA3-512, 3 SHA3-384, 4 SHA3-256, 5 SHA3-224, others SHA3-256; sampled with start_i.
outlen_i  input  OUTLEN_W  requested output bits for modes 0/1; multiple of 8; ignored for fixed-length modes.
state_i  input  [0:1599]  permutation state, lane-packed with each 64-bit lane byte-swapped (same packing the absorb path produces).
state_valid_i  input  1  single-cycle strobe: state_i holds a fresh permuted state.
perm_req_o  output  1  single-cycle request for one more permutation of the current state.
dout_o  output  [0:63]  output word; dout_o[0:7] is the earliest output byte.
dout_nbytes_o  output  4  valid bytes in dout_o, 1..8; unused trailing bytes are zero.
dout_valid_o  output  1  dout_o is valid.
dout_ready_i  input  1  downstream accepts the word.
dout_last_o  output  1  the current word is the final word of the request.
busy_o  output  1  high in every state except IDLE.
done_o  output  1  single-cycle pulse after the request completes.

Behaviour:
- Reset: state IDLE. perm_req_o, dout_valid_o, dout_last_o, busy_o and done_o are 0. dout_o is 0 and dout_nbytes_o is 0. All counters are cleared. Reset takes effect in any state, including mid-stream, and drops dout_valid_o immediately.
- Rate words per mode: 21, 17, 9, 13, 17, 18 (default 17), for rates 1344, 1088, 576, 832, 1088, 1152.
- Output bytes per mode: SHAKE uses outlen_i/8. The fixed-length modes are 64, 48, 32, 28 (default 32).
- State IDLE:
  - On start_i: latch the mode, rate_words and rem_bytes, then move to WAIT.
  - If the mode is SHAKE and outlen_i==0: stay in IDLE and pulse done_o the next cycle. perm_req_o is never raised in this case.
- State WAIT:
  - On state_valid_i: capture lanes 0..rate_words-1 into a buffer of at most 21 lanes, set word index idx=0, and move to EMIT.
  - dout_valid_o rises in the cycle after the strobe.
- State EMIT:
  - dout_o = byteswap(buffer lane idx), i.e. lane byte 0 (bits [56:63] of the lane) becomes dout_o[0:7].
  - dout_nbytes_o = min(8, rem_bytes). Bytes at or beyond dout_nbytes_o are forced to zero.
  - dout_last_o = (rem_bytes<=8).
  - dout_o, dout_nbytes_o and dout_last_o stay stable while dout_valid_o=1 and dout_ready_i=0.
  - On handshake with the last word: go to IDLE, pulse done_o next cycle, drop dout_valid_o.
  - On handshake when idx==rate_words-1 and more bytes remain: go to REQ.
  - On any other handshake: idx++ and rem_bytes -= 8. The next word may be presented the following cycle, giving back-to-back throughput of 1 word/cycle.
- State REQ: perm_req_o=1 for exactly one cycle, then go to WAIT. Only SHAKE modes can reach REQ.
- Ignored inputs:
  - state_valid_i outside WAIT has no effect.
  - start_i outside IDLE has no effect, and its mode and length are not captured.
- Latency:
  - start_i to WAIT: 1 cycle.
  - state_valid_i to first dout_valid_o: 1 cycle.
  - Final handshake to done_o: 1 cycle.

Test Plan:
- SHA3-256, state lane0 = 64'h66d71ebff8c6ffa7 -> first dout_o = 64'ha7ffc6f8bf1ed766. Expect 4 words, each with nbytes 8; last on word 3; done_o once; perm_req_o never.
- SHA3-224 -> 4 words, the last with dout_nbytes_o=4 and dout_o[32:63]=0; dout_last_o only on word 3.
- SHAKE128, outlen_i=1352 -> 21 words, then perm_req_o for 1 cycle. After the second state_valid_i, 1 word with nbytes=1 and last=1; total bytes 169.
- Backpressure: dout_ready_i low for 5 cycles mid-stream -> dout_o/nbytes/last unchanged, no word skipped or duplicated; then ready held high gives 1 word/cycle.
- SHAKE256, outlen_i=0 -> done_o pulse 1 cycle after start, no dout_valid_o, no perm_req_o. start_i pulsed during EMIT is ignored and the stream finishes unchanged.
- rst_n asserted during EMIT word 5 -> all outputs 0 immediately. After release, a new SHA3-512 request streams 8 words correctly.
